// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART line processing stage.
// Also holds the ASCII upper-case helper used on the transmit path.
package uart_pkg;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_DEL   = 8'h7F;
    localparam logic [7:0] ASCII_LC_A  = 8'h61;
    localparam logic [7:0] ASCII_LC_Z  = 8'h7A;
    localparam logic [7:0] CASE_OFFSET = 8'h20;

    localparam logic [1:0] ST_ENC_COLLECT = 2'd0;
    localparam logic [1:0] ST_ENC_SEND    = 2'd1;
    localparam logic [1:0] ST_ENC_SEND_CR = 2'd2;
    localparam logic [1:0] ST_ENC_SEND_LF = 2'd3;

    typedef enum logic [1:0] {
        ST_COLLECT = ST_ENC_COLLECT,
        ST_SEND    = ST_ENC_SEND,
        ST_SEND_CR = ST_ENC_SEND_CR,
        ST_SEND_LF = ST_ENC_SEND_LF
    } state_t;

    function automatic logic [7:0] to_upper(input logic [7:0] b);
        logic [7:0] r;
        if ((b >= ASCII_LC_A) && (b <= ASCII_LC_Z)) begin
            r = b - CASE_OFFSET;
        end else begin
            r = b;
        end
        return r;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Byte line buffer: synchronous write port, asynchronous read port.
// Contents are not reset; validity is tracked by the owner's length counter.
module line_buffer #(
    parameter int MAX_LEN = 16,
    parameter int AW      = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_r [MAX_LEN];

    // Store one byte per write strobe
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/uart_line_processor.sv
// Pops RX bytes into a line buffer with backspace editing and, on CR/LF,
// pushes the upper-cased line followed by CR LF into the TX FIFO.
module uart_line_processor
    import uart_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 5
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             rx_empty,
    input  logic [7:0]       rx_data,
    output logic             rd_uart,
    input  logic             tx_full,
    output logic [7:0]       wr_data,
    output logic             wr_uart,
    output logic [CNT_W-1:0] line_len,
    output logic             overflow,
    output logic             busy
);

    localparam int AW = $clog2(MAX_LEN);

    state_t           state_r;
    logic [CNT_W-1:0] idx_r;
    logic [CNT_W-1:0] idx_next_s;
    logic             pop_s;
    logic             is_term_s;
    logic             is_bs_s;
    logic             room_s;
    logic             store_s;
    logic             push_ok_s;
    logic [7:0]       rdata_s;

    // Gating on rd_uart guarantees an idle cycle between pops for the FIFO flag
    assign pop_s      = (state_r == ST_COLLECT) && !rx_empty && !rd_uart;
    assign is_term_s  = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);
    assign is_bs_s    = (rx_data == ASCII_BS) || (rx_data == ASCII_DEL);
    assign room_s     = (line_len < CNT_W'(MAX_LEN));
    assign store_s    = pop_s && !is_term_s && !is_bs_s && room_s;
    assign push_ok_s  = !tx_full && !wr_uart;
    assign idx_next_s = idx_r + CNT_W'(1);

    line_buffer #(
        .MAX_LEN (MAX_LEN),
        .AW      (AW)
    ) u_line_buffer (
        .clk   (CLK),
        .we    (store_s),
        .waddr (line_len[AW-1:0]),
        .wdata (rx_data),
        .raddr (idx_r[AW-1:0]),
        .rdata (rdata_s)
    );

    // Line collection / transmission FSM with registered strobes and status
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r  <= ST_COLLECT;
            idx_r    <= '0;
            line_len <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            rd_uart  <= 1'b0;
            wr_uart  <= 1'b0;
            wr_data  <= 8'h00;
        end else begin
            case (state_r)
                ST_COLLECT: begin
                    wr_uart <= 1'b0;
                    busy    <= 1'b0;
                    rd_uart <= pop_s;
                    if (pop_s) begin
                        if (is_term_s) begin
                            if (line_len != '0) begin
                                idx_r   <= '0;
                                state_r <= ST_SEND;
                            end
                        end else if (is_bs_s) begin
                            if (line_len != '0) begin
                                line_len <= line_len - CNT_W'(1);
                            end
                        end else if (room_s) begin
                            line_len <= line_len + CNT_W'(1);
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    rd_uart <= 1'b0;
                    busy    <= 1'b1;
                    if (push_ok_s) begin
                        wr_data <= to_upper(rdata_s);
                        wr_uart <= 1'b1;
                        idx_r   <= idx_next_s;
                        if (idx_next_s == line_len) begin
                            state_r <= ST_SEND_CR;
                        end
                    end else begin
                        wr_uart <= 1'b0;
                    end
                end
                ST_SEND_CR: begin
                    rd_uart <= 1'b0;
                    busy    <= 1'b1;
                    if (push_ok_s) begin
                        wr_data <= ASCII_CR;
                        wr_uart <= 1'b1;
                        state_r <= ST_SEND_LF;
                    end else begin
                        wr_uart <= 1'b0;
                    end
                end
                ST_SEND_LF: begin
                    rd_uart <= 1'b0;
                    if (push_ok_s) begin
                        wr_data  <= ASCII_LF;
                        wr_uart  <= 1'b1;
                        line_len <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b0;
                        state_r  <= ST_COLLECT;
                    end else begin
                        wr_uart <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_COLLECT;
                    rd_uart <= 1'b0;
                    wr_uart <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_line_processor.sv
// Directed bench for uart_line_processor with small RX/TX FIFO models.
module tb_uart_line_processor;

    localparam int MAX_LEN = 16;
    localparam int CNT_W   = 5;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             rx_empty;
    logic [7:0]       rx_data;
    logic             rd_uart;
    logic             tx_full;
    logic [7:0]       wr_data;
    logic             wr_uart;
    logic [CNT_W-1:0] line_len;
    logic             overflow;
    logic             busy;

    int   tests = 0;
    int   fails = 0;
    logic prev_rd = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];

    always #5 CLK = ~CLK;

    uart_line_processor #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .rx_empty (rx_empty),
        .rx_data  (rx_data),
        .rd_uart  (rd_uart),
        .tx_full  (tx_full),
        .wr_data  (wr_data),
        .wr_uart  (wr_uart),
        .line_len (line_len),
        .overflow (overflow),
        .busy     (busy)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh_rx();
        rx_empty = (rx_q.size() == 0);
        rx_data  = rx_empty ? 8'h00 : rx_q[0];
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_q.push_back(b);
        refresh_rx();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            rx_push(8'(s[i]));
        end
    endtask

    // One clock: check strobe rules, then update FIFO models from this cycle's strobes
    task automatic tick();
        logic       rd;
        logic       wr;
        logic [7:0] wd;
        rd = rd_uart;
        wr = wr_uart;
        wd = wr_data;
        chk("no_back_to_back_pop", int'(rd & prev_rd), 0);
        chk("rd_wr_exclusive", int'(rd & wr), 0);
        chk("no_pop_while_busy", int'(rd & busy), 0);
        if (rd) begin
            chk("pop_nonempty", int'(rx_q.size() != 0), 1);
        end
        prev_rd = rd;
        @(posedge CLK);
        #1;
        if (rd && (rx_q.size() != 0)) begin
            void'(rx_q.pop_front());
        end
        if (wr) begin
            tx_q.push_back(wd);
        end
        refresh_rx();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    task automatic wait_tx(input string tag, input int n);
        int k;
        k = 0;
        while ((tx_q.size() < n) && (k < 200)) begin
            tick();
            k++;
        end
        chk(tag, tx_q.size(), n);
    endtask

    // Expect the given text upper-cased by hand, followed by CR LF
    task automatic expect_tx(input string tag, input string s);
        int n;
        n = s.len() + 2;
        chk({tag, "_count"}, tx_q.size(), n);
        for (int i = 0; i < s.len(); i++) begin
            if (i < tx_q.size()) begin
                chk({tag, "_byte"}, int'(tx_q[i]), int'(s[i]));
            end
        end
        if (tx_q.size() == n) begin
            chk({tag, "_cr"}, int'(tx_q[n-2]), 32'h0D);
            chk({tag, "_lf"}, int'(tx_q[n-1]), 32'h0A);
        end
        tx_q.delete();
    endtask

    initial begin
        RST_N   = 1'b0;
        tx_full = 1'b0;
        refresh_rx();
        @(posedge CLK);
        #1;
        chk("rst_rd_uart", int'(rd_uart), 0);
        chk("rst_wr_uart", int'(wr_uart), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_line_len", int'(line_len), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        run(2);
        RST_N = 1'b1;
        run(2);

        // Basic line
        send_str("abc");
        rx_push(8'h0D);
        run(30);
        expect_tx("abc", "ABC");
        chk("abc_busy", int'(busy), 0);
        chk("abc_len", int'(line_len), 0);

        // Backspace editing, then lone CR LF
        send_str("ab");
        run(6);
        chk("ab_len", int'(line_len), 2);
        rx_push(8'h08);
        run(4);
        chk("bs_len", int'(line_len), 1);
        send_str("c");
        rx_push(8'h0D);
        run(30);
        expect_tx("bs", "AC");
        rx_push(8'h0D);
        rx_push(8'h0A);
        run(10);
        chk("lone_crlf_nopush", tx_q.size(), 0);
        chk("lone_crlf_len", int'(line_len), 0);

        // Overflow on byte 17
        send_str("0123456789abcdefg");
        run(40);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_len", int'(line_len), 16);
        rx_push(8'h0D);
        run(50);
        expect_tx("ovf", "0123456789ABCDEF");
        chk("ovf_cleared", int'(overflow), 0);

        // Backspace after overflow keeps overflow set
        send_str("0123456789abcdefg");
        run(40);
        rx_push(8'h7F);
        run(4);
        chk("ovf_bs_len", int'(line_len), 15);
        chk("ovf_bs_flag", int'(overflow), 1);
        rx_push(8'h0D);
        run(50);
        expect_tx("ovf_bs", "0123456789ABCDE");

        // TX stall after second push
        send_str("hello");
        rx_push(8'h0D);
        wait_tx("hello_two_pushed", 2);
        tx_full = 1'b1;
        run(50);
        chk("stall_no_push", tx_q.size(), 2);
        chk("stall_busy", int'(busy), 1);
        tx_full = 1'b0;
        run(30);
        expect_tx("hello", "HELLO");

        // Reset mid-transmission
        send_str("wxyz");
        rx_push(8'h0D);
        wait_tx("rst_mid_first_push", 1);
        RST_N = 1'b0;
        tick();
        chk("rst_mid_wr_uart", int'(wr_uart), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_len", int'(line_len), 0);
        RST_N = 1'b1;
        tx_q.delete();
        run(2);
        send_str("x");
        rx_push(8'h0D);
        run(20);
        expect_tx("after_rst", "X");

        // Case boundaries and non-letters
        send_str("`az{ Hi 1");
        rx_push(8'h0A);
        run(60);
        expect_tx("bounds", "`AZ{ HI 1");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_line_processor.md
Name: uart_line_processor

Overview:
- Consumer/producer stage sitting between the uart_top RX FIFO and TX FIFO.
- Replaces free-running read/write strobes with a proper handshake:
  - pops received bytes one at a time into a line buffer;
  - handles backspace;
  - on end-of-line, pushes the line back to the TX FIFO upper-cased, followed by CR LF.
- Drives status for LEDs and the 7-segment display.

Parameters:
- MAX_LEN, 16, line buffer depth in bytes (power of 2, 4..64).
- CNT_W, 5, width of the length counter; must satisfy 2^CNT_W > MAX_LEN.

Ports:
- CLK  in  1  system clock (100 MHz).
- RST_N  in  1  synchronous active-low reset, sampled on rising CLK.
- rx_empty  in  1  RX FIFO empty flag from uart_top.
- rx_data  in  8  RX FIFO head byte (first-word fall-through, valid when rx_empty=0).
- rd_uart  out  1  one-cycle pop strobe to the RX FIFO.
- tx_full  in  1  TX FIFO full flag.
- wr_data  out  8  byte to the TX FIFO.
- wr_uart  out  1  one-cycle push strobe to the TX FIFO.
- line_len  out  CNT_W  current number of buffered bytes.
- overflow  out  1  sticky; set when a byte is dropped because the buffer is full.
- busy  out  1  high while a line is being transmitted.

Behaviour:
- Reset (RST_N=0 at a rising CLK), applies in any state, including mid-transmission:
  - state := COLLECT;
  - rd_uart, wr_uart, busy, overflow := 0;
  - line_len := 0; wr_data := 8'h00;
  - buffer contents are don't-care;
  - no partial line is resumed.
- States: COLLECT, SEND, SEND_CR, SEND_LF.
- COLLECT:
  - if rx_empty=0, assert rd_uart for exactly one cycle and capture rx_data in that same cycle;
  - never two consecutive pops: at least one idle cycle between pops so the FIFO flag can update.
  - Captured byte handling:
    - 8'h0D (CR) or 8'h0A (LF): if line_len>0, go to SEND with index:=0; else discard (this swallows the LF of a CRLF pair).
    - 8'h08 (BS) or 8'h7F (DEL): line_len := line_len-1 if line_len>0; else no effect.
    - Any other byte:
      - if line_len<MAX_LEN, store it at buf[line_len] and increment line_len;
      - else drop it and set overflow:=1.
- SEND:
  - busy=1; no RX pops.
  - Each cycle with tx_full=0 and wr_uart low the previous cycle:
    - wr_data := upper(buf[index]); wr_uart := 1 for one cycle; index++.
  - After index reaches line_len, go to SEND_CR.
  - If tx_full=1, hold with no push.
- upper(b): b-8'h20 if 8'h61<=b<=8'h7A, else b unchanged.
- SEND_CR: push 8'h0D under the same tx_full rule, then go to SEND_LF.
- SEND_LF:
  - push 8'h0A;
  - then line_len:=0, overflow:=0, busy:=0, go to COLLECT.
- Latency:
  - RX pop occurs 1 cycle after rx_empty falls in COLLECT.
  - First TX push occurs 1 cycle after the terminator is captured, if tx_full=0.
- Strobe timing:
  - wr_data is stable in the cycle wr_uart=1;
  - rd_uart and wr_uart are never high in the same cycle.
- Boundary conditions:
  - Exactly MAX_LEN bytes then CR: the full line is sent; overflow stays 0.
  - Byte MAX_LEN+1: dropped, overflow=1; the stored bytes still transmit on the next CR.
  - BS after overflow: removes the last stored byte; overflow remains set until the line is sent.
  - tx_full rising mid-line: stalls indefinitely without losing or duplicating bytes.
- Width: index and line_len are CNT_W bits; no wrap-around is possible by construction.

Decomposition:
- Shared package uart_pkg:
  - ASCII constants: ASCII_CR, ASCII_LF, ASCII_BS, ASCII_DEL, ASCII_LC_A, ASCII_LC_Z, CASE_OFFSET;
  - state encoding localparams.
- Sub-module line_buffer: MAX_LEN x 8 register array with synchronous write (we, waddr) and asynchronous read (raddr).
- The FSM and counters stay in uart_line_processor.

Test Plan:
- Send "abc",CR with tx_full=0 -> TX pushes 8'h41,8'h42,8'h43,8'h0D,8'h0A in order; busy returns to 0; line_len=0.
- Send "ab",BS,"c",CR -> TX pushes "AC",CR,LF; a lone CR then LF produces no pushes.
- Send 17 bytes "0".."9","a".."g" with MAX_LEN=16, then CR:
  - overflow=1 after byte 17;
  - TX gets "0123456789ABCDEF",CR,LF;
  - overflow clears after the LF.
- Hold tx_full=1 after the 2nd push of "hello",CR, release after 50 cycles -> exact sequence "HELLO",CR,LF, no duplicates; no rd_uart while busy.
- Assert RST_N=0 for one cycle mid-SEND -> next cycle wr_uart=0, busy=0, line_len=0; subsequent "x",CR yields "X",CR,LF.
- Keep rx_empty=0 continuously -> rd_uart never high on two consecutive cycles.
